// File: rtl/clk_period_meter.sv
// Measures the rising-to-rising period, lock status and timeout of a slow signal that is asynchronous to clk_in.
// Define DUTY_CHECK_EN to enable high-time measurement and the duty_err flag.
module clk_period_meter #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 3
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout,
    output logic             duty_err
);

    localparam int                 MATCH_W   = 4;
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_TOP = MATCH_W'(LOCK_N - 1);

    typedef enum logic {
        ARM  = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q, s3_q;
    logic               rise;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               meas_valid_q, meas_valid_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               prev_ok_q, prev_ok_d;

    // s1/s2 are the synchronizer; s3 only remembers the previous synchronized level for edge detection.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage takes its neighbour's pre-edge value and the chain stays three flops deep.
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    always_comb begin
        // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;
        match_d      = match_q;
        prev_ok_d    = prev_ok_q;

        case (state_q)
            ARM: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = CNT_ONE;
                end
            end
            MEAS: begin
                if (rise) begin
                    // A rise wins over a simultaneous timeout: a full-scale count is a legal period.
                    period_d     = cnt_q;
                    meas_valid_d = 1'b1;
                    cnt_d        = CNT_ONE;
                    timeout_d    = 1'b0;
                    prev_ok_d    = 1'b1;
                    if (prev_ok_q && (cnt_q == period_q)) begin
                        match_d = (match_q == MATCH_TOP) ? match_q : match_q + MATCH_ONE;
                    end else begin
                        match_d = '0;
                    end
                    locked_d = (match_d == MATCH_TOP);
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ARM;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = '0;
                    prev_ok_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= ARM;
            cnt_q        <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            match_q      <= '0;
            prev_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
            match_q      <= match_d;
            prev_ok_q    <= prev_ok_d;
        end
    end

    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

`ifdef DUTY_CHECK_EN
    localparam logic [CNT_W:0] IMB_ONE = (CNT_W+1)'(1);

    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             duty_err_q, duty_err_d;
    logic [CNT_W:0]   twice_high, cnt_ext, imbalance;
    logic             meas_evt, timeout_evt;

    assign meas_evt    = (state_q == MEAS) && rise;
    assign timeout_evt = (state_q == MEAS) && !rise && (cnt_q == CNT_MAX);
    assign twice_high  = {high_cnt_q, 1'b0};
    assign cnt_ext     = {1'b0, cnt_q};
    assign imbalance   = (twice_high >= cnt_ext) ? (twice_high - cnt_ext) : (cnt_ext - twice_high);

    always_comb begin
        high_cnt_d  = high_cnt_q;
        high_time_d = high_time_q;
        duty_err_d  = duty_err_q;
        if (state_q == ARM) begin
            high_cnt_d = rise ? CNT_ONE : '0;
        end else if (meas_evt) begin
            high_time_d = high_cnt_q;
            high_cnt_d  = CNT_ONE;
            duty_err_d  = (imbalance > IMB_ONE);
        end else if (timeout_evt) begin
            high_cnt_d = '0;
            duty_err_d = 1'b0;
        end else if (s2_q && (high_cnt_q != CNT_MAX)) begin
            high_cnt_d = high_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            high_cnt_q  <= '0;
            high_time_q <= '0;
            duty_err_q  <= 1'b0;
        end else begin
            high_cnt_q  <= high_cnt_d;
            high_time_q <= high_time_d;
            duty_err_q  <= duty_err_d;
        end
    end

    assign high_time = high_time_q;
    assign duty_err  = duty_err_q;
`else
    assign high_time = '0;
    assign duty_err  = 1'b0;
`endif

endmodule
